csr_unit: RTL and testbench
===========================

# csr_unit

Machine-mode control/status register file for the RISC-V core, replacing the minimal mstatus/mepc/mcycle block. It adds parametrised interrupt lines with enable/pending registers and fixed priority, trap-entry and mret sequencing, and direct or vectored trap vectors. It also provides 64-bit-capable cycle and instret counters. It sits beside the execute stage: the decoder drives CSR accesses, and the pipeline controller consumes irq/trap outputs.

## Interface
Parameters:
- NUM_IRQ, 4: platform interrupt lines (1..16), mapped to mip/mie bits 16+k
- CNT_WIDTH, 64: implemented counter width (33..64); bits above read 0
- MTVEC_RESET, 32'h0000_0000: mtvec reset value
- HART_ID, 0: mhartid value

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- op_i  in  2  CSR_OP_NONE/WRITE/SET/CLEAR
- addr_i  in  12  CSR address
- wdata_i  in  32  write/set/clear operand
- rdata_o  out  32  current value at addr_i (combinational)
- illegal_o  out  1  access is illegal this cycle
- trap_i  in  1  take trap this cycle
- cause_i  in  32  mcause value for trap (bit31 = interrupt)
- pc_i  in  32  PC saved into mepc on trap
- mret_i  in  1  return from trap
- retire_i  in  1  one instruction retired
- irq_i  in  NUM_IRQ  level interrupt lines
- irq_req_o  out  1  interrupt pending and globally enabled
- irq_cause_o  out  32  {1'b1, 26'h0, 16+idx} of winning line
- tvec_o  out  32  trap target for cause_i
- epc_o  out  32  mepc

## Operation
- Map: 300 mstatus, 304 mie, 305 mtvec, 340 mscratch, 341 mepc, 342 mcause, 344 mip(RO), B00/B80 mcycle lo/hi, B02/B82 minstret lo/hi, C00/C80/C02/C82 RO shadows, F14 mhartid(RO).
- mstatus reads {19'h0, 2'b11 MPP, 3'h0, MPIE, 3'h0, MIE, 3'h0}; only bits 7 and 3 writable.
- Write value: WRITE=wdata_i, SET=rdata|wdata_i, CLEAR=rdata&~wdata_i. A write happens when op_i!=NONE, except SET/CLEAR with wdata_i==0, which are read-only.
- illegal_o=1 for any op on an unmapped address, or for a write to a RO address. Illegal accesses change no state; rdata_o=0 for unmapped addresses.
- mepc[1:0] and mtvec[1] are forced 0. mtvec[0] is the mode: 0=direct, 1=vectored.
- tvec_o = base, except vectored mode with cause_i[31]=1, which gives base + 4*cause_i[4:0].
- mip[16+k] = irq_i[k] after one register stage.
- pending = mip & mie. irq_req_o = MIE & |pending. The lowest index wins.
- trap_i: mepc<=pc_i, mcause<=cause_i, MPIE<=MIE, MIE<=0.
- mret_i: MIE<=MPIE, MPIE<=1.
- Same-cycle priority: trap_i > mret_i > CSR write (for mstatus/mepc/mcause). Other CSR writes still occur.
- Counters: mcycle +1 every cycle; minstret +1 when retire_i.
  - A write to the lo or hi half replaces that half and suppresses the increment that cycle.
  - Carry from lo to hi is within CNT_WIDTH; wraps to 0 at all-ones.

## Timing
- All state updates at posedge clk; rdata_o, illegal_o and tvec_o are combinational from current state and inputs.
- A write is visible on rdata_o the cycle after.
- irq_i to irq_req_o latency is 1 cycle when enabled. Clearing mie or MIE drops irq_req_o the next cycle.
- Reset values: all registers 0 except mtvec=MTVEC_RESET and mip sync stage=0. Therefore irq_req_o=0, epc_o=0 and tvec_o=MTVEC_RESET&~2 in reset.
- Reset asserted mid-operation aborts any write or trap immediately.

## Structure
- Shared package csr_defines.v holds:
  - CSR addresses
  - mstatus bit positions
  - IRQ base code 16
  - CSR_OP_* codes (existing, in riscv_defines.v)
- Sub-module csr_counter (params CNT_WIDTH) with inputs inc, wr_lo, wr_hi, wdata and output value. Instantiated twice.

## Test plan
- Reset, then read 305, B00, 300 → MTVEC_RESET; 0 then 1 on the following cycle; 32'h0000_1800.
- WRITE 304=32'h0001_0000, SET 300=8, raise irq_i[0] → irq_req_o=1 one cycle later, irq_cause_o=32'h8000_0010. Raise irq_i[2] too → cause unchanged.
- trap_i with pc_i=32'h0000_0123 and cause_i=11 → mepc=32'h120, mcause=11, MIE=0, MPIE=1. Then mret_i → MIE=1, MPIE=1.
- mtvec=32'h0000_1001, cause_i=32'h8000_0011 → tvec_o=32'h0000_1044. With cause_i=2 → 32'h0000_1000.
- WRITE B00=32'hFFFF_FFFF, then 2 cycles → B80 reads 1, B00 reads 1. WRITE C00 → illegal_o=1, no change.
- Same cycle: trap_i plus WRITE 341=32'h40 → mepc=pc_i. A CLEAR on 301 → illegal_o=1.

Source files
------------

// File: rtl/csr_unit_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, op codes,
// mstatus layout and interrupt numbering.
package csr_unit_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'd0,
        CSR_OP_WRITE = 2'd1,
        CSR_OP_SET   = 2'd2,
        CSR_OP_CLEAR = 2'd3
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam logic [1:0]  MSTATUS_MPP_M    = 2'b11;

    localparam int unsigned IRQ_BASE = 16;

    typedef struct packed {
        logic mpie;
        logic mie;
    } mstatus_t;

    // MPP is hardwired to machine mode; only MIE and MPIE are stored.
    function automatic logic [31:0] mstatus_read(input mstatus_t s);
        return {19'h0, MSTATUS_MPP_M, 3'h0, s.mpie, 3'h0, s.mie, 3'h0};
    endfunction

endpackage

// File: rtl/csr_unit_counter.sv
// Split-access counter: 32-bit low half plus (CNT_WIDTH-32)-bit high half,
// with half writes taking precedence over the increment.
module csr_unit_counter #(
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc_i,
    input  logic                 wr_lo_i,
    input  logic                 wr_hi_i,
    input  logic [31:0]          wdata_i,
    output logic [CNT_WIDTH-1:0] value_o
);

    localparam int unsigned HI_W = CNT_WIDTH - 32;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) cnt_d[31:0] = wdata_i;
            if (wr_hi_i) cnt_d[CNT_WIDTH-1:32] = wdata_i[HI_W-1:0];
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign value_o = cnt_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: interrupt enable/pending with fixed priority,
// trap entry / mret sequencing, direct or vectored trap vectors, counters.
module csr_unit
    import csr_unit_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 4,
    parameter int unsigned CNT_WIDTH   = 64,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         op_i,
    input  logic [11:0]        addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic               illegal_o,
    input  logic               trap_i,
    input  logic [31:0]        cause_i,
    input  logic [31:0]        pc_i,
    input  logic               mret_i,
    input  logic               retire_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic               irq_req_o,
    output logic [31:0]        irq_cause_o,
    output logic [31:0]        tvec_o,
    output logic [31:0]        epc_o
);

    mstatus_t             mstat_q, mstat_d;
    logic [NUM_IRQ-1:0]   mie_q, mie_d, mip_q;
    logic [31:0]          mtvec_q, mtvec_d;
    logic [31:0]          mscratch_q, mscratch_d;
    logic [31:0]          mepc_q, mepc_d;
    logic [31:0]          mcause_q, mcause_d;
    logic [CNT_WIDTH-1:0] mcycle_val, minstret_val;

    logic [31:0] rdata_c, wval_c, tvec_c, irq_cause_c;
    logic        mapped_c, ro_c, wr_req_c, wr_en_c;
    logic [NUM_IRQ-1:0] pending_c;
    logic [4:0]  irq_idx_c;

    // Read mux plus address classification.
    always_comb begin
        rdata_c  = '0;
        mapped_c = 1'b1;
        ro_c     = 1'b0;
        case (addr_i)
            CSR_MSTATUS:   rdata_c = mstatus_read(mstat_q);
            CSR_MIE:       rdata_c = 32'(mie_q) << IRQ_BASE;
            CSR_MTVEC:     rdata_c = mtvec_q;
            CSR_MSCRATCH:  rdata_c = mscratch_q;
            CSR_MEPC:      rdata_c = mepc_q;
            CSR_MCAUSE:    rdata_c = mcause_q;
            CSR_MIP:       begin rdata_c = 32'(mip_q) << IRQ_BASE; ro_c = 1'b1; end
            CSR_MCYCLE:    rdata_c = mcycle_val[31:0];
            CSR_MCYCLEH:   rdata_c = 32'(mcycle_val[CNT_WIDTH-1:32]);
            CSR_MINSTRET:  rdata_c = minstret_val[31:0];
            CSR_MINSTRETH: rdata_c = 32'(minstret_val[CNT_WIDTH-1:32]);
            CSR_CYCLE:     begin rdata_c = mcycle_val[31:0]; ro_c = 1'b1; end
            CSR_CYCLEH:    begin rdata_c = 32'(mcycle_val[CNT_WIDTH-1:32]); ro_c = 1'b1; end
            CSR_INSTRET:   begin rdata_c = minstret_val[31:0]; ro_c = 1'b1; end
            CSR_INSTRETH:  begin rdata_c = 32'(minstret_val[CNT_WIDTH-1:32]); ro_c = 1'b1; end
            CSR_MHARTID:   begin rdata_c = HART_ID; ro_c = 1'b1; end
            default:       mapped_c = 1'b0;
        endcase
    end

    // SET/CLEAR with a zero mask are pure reads and never count as writes.
    always_comb begin
        wval_c = wdata_i;
        case (op_i)
            CSR_OP_SET:   wval_c = rdata_c | wdata_i;
            CSR_OP_CLEAR: wval_c = rdata_c & ~wdata_i;
            default:      wval_c = wdata_i;
        endcase
        wr_req_c = (op_i != CSR_OP_NONE) &&
                   !(((op_i == CSR_OP_SET) || (op_i == CSR_OP_CLEAR)) && (wdata_i == 32'h0));
        wr_en_c  = wr_req_c && mapped_c && !ro_c;
    end

    assign illegal_o = (op_i != CSR_OP_NONE) && (!mapped_c || (ro_c && wr_req_c));
    assign rdata_o   = mapped_c ? rdata_c : 32'h0;

    // Next-state: CSR write first, then mret, then trap override it.
    always_comb begin
        mstat_d    = mstat_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (wr_en_c) begin
            case (addr_i)
                CSR_MSTATUS: begin
                    mstat_d.mie  = wval_c[MSTATUS_MIE_BIT];
                    mstat_d.mpie = wval_c[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_d      = wval_c[IRQ_BASE +: NUM_IRQ];
                CSR_MTVEC:    mtvec_d    = wval_c & ~32'h2;
                CSR_MSCRATCH: mscratch_d = wval_c;
                CSR_MEPC:     mepc_d     = wval_c & ~32'h3;
                CSR_MCAUSE:   mcause_d   = wval_c;
                default:      ;
            endcase
        end
        if (trap_i) begin
            mepc_d       = pc_i & ~32'h3;
            mcause_d     = cause_i;
            mstat_d.mpie = mstat_q.mie;
            mstat_d.mie  = 1'b0;
        end else if (mret_i) begin
            mstat_d.mie  = mstat_q.mpie;
            mstat_d.mpie = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstat_q    <= '0;
            mie_q      <= '0;
            mip_q      <= '0;
            mtvec_q    <= MTVEC_RESET & ~32'h2;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mstat_q    <= mstat_d;
            mie_q      <= mie_d;
            mip_q      <= irq_i;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    // Lowest-numbered pending line wins; scan downward so it is assigned last.
    always_comb begin
        pending_c = mip_q & mie_q;
        irq_idx_c = '0;
        for (int k = int'(NUM_IRQ) - 1; k >= 0; k--) begin
            if (pending_c[k]) irq_idx_c = 5'(k);
        end
        irq_cause_c = (|pending_c) ? {1'b1, 26'h0, 5'(IRQ_BASE) + irq_idx_c} : 32'h0;
    end

    assign irq_req_o   = mstat_q.mie && (|pending_c);
    assign irq_cause_o = irq_cause_c;
    assign epc_o       = mepc_q;

    always_comb begin
        tvec_c = {mtvec_q[31:2], 2'b00};
        if (mtvec_q[0] && cause_i[31]) tvec_c = tvec_c + {25'h0, cause_i[4:0], 2'b00};
    end
    assign tvec_o = tvec_c;

    csr_unit_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (1'b1),
        .wr_lo_i (wr_en_c && (addr_i == CSR_MCYCLE)),
        .wr_hi_i (wr_en_c && (addr_i == CSR_MCYCLEH)),
        .wdata_i (wval_c),
        .value_o (mcycle_val)
    );

    csr_unit_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (retire_i),
        .wr_lo_i (wr_en_c && (addr_i == CSR_MINSTRET)),
        .wr_hi_i (wr_en_c && (addr_i == CSR_MINSTRETH)),
        .wdata_i (wval_c),
        .value_o (minstret_val)
    );

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: expectations are queued as stimulus is
// driven and checked in order as the DUT outputs are sampled.
module tb_csr_unit;
    import csr_unit_pkg::*;

    localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
    localparam logic [31:0] HART      = 32'h0000_0005;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  op_i;
    logic [11:0] addr_i;
    logic [31:0] wdata_i, rdata_o, cause_i, pc_i, irq_cause_o, tvec_o, epc_o;
    logic        illegal_o, trap_i, mret_i, retire_i, irq_req_o;
    logic [3:0]  irq_i;

    csr_unit #(
        .NUM_IRQ(4), .CNT_WIDTH(64), .MTVEC_RESET(MTVEC_RST), .HART_ID(HART)
    ) dut (
        .clk(clk), .rst_n(rst_n), .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rdata_o(rdata_o), .illegal_o(illegal_o), .trap_i(trap_i), .cause_i(cause_i),
        .pc_i(pc_i), .mret_i(mret_i), .retire_i(retire_i), .irq_i(irq_i),
        .irq_req_o(irq_req_o), .irq_cause_o(irq_cause_o), .tvec_o(tvec_o), .epc_o(epc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_entry_t;

    typedef enum int { O_IRQ_REQ, O_IRQ_CAUSE, O_TVEC, O_EPC, O_ILLEGAL } out_sel_e;

    sb_entry_t sb_q[$];
    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        sb_entry_t e;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_underflow: got %08h with no expectation queued", obs);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        sb_push(tag, exp);
        op_i   = CSR_OP_NONE;
        addr_i = a;
        #1;
        sb_pop(rdata_o);
    endtask

    task automatic out_chk(input string tag, input out_sel_e sel, input logic [31:0] exp);
        logic [31:0] obs;
        sb_push(tag, exp);
        #1;
        case (sel)
            O_IRQ_REQ:   obs = {31'h0, irq_req_o};
            O_IRQ_CAUSE: obs = irq_cause_o;
            O_TVEC:      obs = tvec_o;
            O_EPC:       obs = epc_o;
            default:     obs = {31'h0, illegal_o};
        endcase
        sb_pop(obs);
    endtask

    task automatic csr_wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        op_i    = op;
        addr_i  = a;
        wdata_i = d;
        tick();
        op_i    = CSR_OP_NONE;
        wdata_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; op_i = CSR_OP_NONE; addr_i = '0; wdata_i = '0;
        trap_i = 1'b0; cause_i = '0; pc_i = '0; mret_i = 1'b0; retire_i = 1'b0; irq_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state; mcycle counts from 0 after release.
        rd_chk("rst_mtvec", CSR_MTVEC, MTVEC_RST);
        rd_chk("rst_mcycle0", CSR_MCYCLE, 32'h0);
        rd_chk("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
        out_chk("rst_irq_req", O_IRQ_REQ, 32'h0);
        out_chk("rst_epc", O_EPC, 32'h0);
        out_chk("rst_tvec", O_TVEC, MTVEC_RST & ~32'h2);
        rd_chk("mhartid", CSR_MHARTID, HART);
        tick();
        rd_chk("rst_mcycle1", CSR_MCYCLE, 32'h1);
        rd_chk("unmapped_rd", 12'h301, 32'h0);

        // Interrupt enable, priority and masking.
        csr_wr(CSR_OP_WRITE, CSR_MIE, 32'h0001_0000);
        rd_chk("mie_wr", CSR_MIE, 32'h0001_0000);
        csr_wr(CSR_OP_SET, CSR_MSTATUS, 32'h8);
        rd_chk("mstatus_set", CSR_MSTATUS, 32'h0000_1808);
        irq_i = 4'b0001;
        out_chk("irq_not_yet", O_IRQ_REQ, 32'h0);
        tick();
        out_chk("irq_req", O_IRQ_REQ, 32'h1);
        out_chk("irq_cause0", O_IRQ_CAUSE, 32'h8000_0010);
        rd_chk("mip0", CSR_MIP, 32'h0001_0000);
        irq_i = 4'b0101;
        tick();
        out_chk("irq_cause_prio", O_IRQ_CAUSE, 32'h8000_0010);
        rd_chk("mip02", CSR_MIP, 32'h0005_0000);
        irq_i = 4'b0100;
        tick();
        out_chk("irq2_masked", O_IRQ_REQ, 32'h0);
        csr_wr(CSR_OP_SET, CSR_MIE, 32'h0004_0000);
        out_chk("irq2_req", O_IRQ_REQ, 32'h1);
        out_chk("irq_cause2", O_IRQ_CAUSE, 32'h8000_0012);
        csr_wr(CSR_OP_CLEAR, CSR_MSTATUS, 32'h8);
        out_chk("irq_mie_off", O_IRQ_REQ, 32'h0);
        csr_wr(CSR_OP_SET, CSR_MSTATUS, 32'h8);
        irq_i = 4'b0000;
        tick();
        out_chk("irq_dropped", O_IRQ_REQ, 32'h0);

        // Trap entry then mret.
        pc_i = 32'h0000_0123; cause_i = 32'd11; trap_i = 1'b1;
        tick();
        trap_i = 1'b0;
        out_chk("trap_epc", O_EPC, 32'h0000_0120);
        rd_chk("trap_mepc", CSR_MEPC, 32'h0000_0120);
        rd_chk("trap_mcause", CSR_MCAUSE, 32'd11);
        rd_chk("trap_mstatus", CSR_MSTATUS, 32'h0000_1880);
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        rd_chk("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);

        // Vectored trap target and forced mtvec bit 1.
        csr_wr(CSR_OP_WRITE, CSR_MTVEC, 32'h0000_1003);
        rd_chk("mtvec_rd", CSR_MTVEC, 32'h0000_1001);
        cause_i = 32'h8000_0011;
        out_chk("tvec_vec", O_TVEC, 32'h0000_1044);
        cause_i = 32'd2;
        out_chk("tvec_exc", O_TVEC, 32'h0000_1000);

        // Counter carry, RO shadow and illegal write.
        csr_wr(CSR_OP_WRITE, CSR_MCYCLE, 32'hFFFF_FFFF);
        rd_chk("mcycle_lo_wr", CSR_MCYCLE, 32'hFFFF_FFFF);
        tick();
        tick();
        rd_chk("mcycleh_carry", CSR_MCYCLEH, 32'h1);
        rd_chk("mcycle_lo", CSR_MCYCLE, 32'h1);
        op_i = CSR_OP_WRITE; addr_i = CSR_CYCLE; wdata_i = 32'h0;
        out_chk("ro_wr_illegal", O_ILLEGAL, 32'h1);
        tick();
        op_i = CSR_OP_NONE;
        rd_chk("ro_no_change", CSR_CYCLE, 32'h2);
        rd_chk("cycleh_shadow", CSR_CYCLEH, 32'h1);
        op_i = CSR_OP_SET; addr_i = CSR_CYCLE; wdata_i = 32'h0;
        out_chk("ro_set0_legal", O_ILLEGAL, 32'h0);
        op_i = CSR_OP_NONE;

        retire_i = 1'b1;
        repeat (3) tick();
        retire_i = 1'b0;
        rd_chk("minstret3", CSR_MINSTRET, 32'h3);
        retire_i = 1'b1;
        csr_wr(CSR_OP_WRITE, CSR_MINSTRET, 32'h10);
        retire_i = 1'b0;
        rd_chk("minstret_wr", CSR_INSTRET, 32'h10);

        // Trap beats a same-cycle mepc write; unmapped CLEAR is illegal.
        csr_wr(CSR_OP_WRITE, CSR_MEPC, 32'h0000_0047);
        rd_chk("mepc_align", CSR_MEPC, 32'h0000_0044);
        pc_i = 32'h0000_0200; cause_i = 32'd7; trap_i = 1'b1;
        csr_wr(CSR_OP_WRITE, CSR_MEPC, 32'h0000_0040);
        trap_i = 1'b0;
        out_chk("trap_beats_wr", O_EPC, 32'h0000_0200);
        rd_chk("trap2_mcause", CSR_MCAUSE, 32'd7);
        op_i = CSR_OP_CLEAR; addr_i = 12'h301; wdata_i = 32'h1;
        out_chk("unmapped_illegal", O_ILLEGAL, 32'h1);
        op_i = CSR_OP_NONE;

        // Reset in the middle of a write aborts it.
        csr_wr(CSR_OP_WRITE, CSR_MSCRATCH, 32'h0000_0055);
        rd_chk("mscratch_wr", CSR_MSCRATCH, 32'h0000_0055);
        op_i = CSR_OP_WRITE; addr_i = CSR_MSCRATCH; wdata_i = 32'h0000_00AA;
        rst_n = 1'b0;
        tick();
        op_i = CSR_OP_NONE;
        rst_n = 1'b1;
        rd_chk("rst_abort_wr", CSR_MSCRATCH, 32'h0);
        rd_chk("rst2_mstatus", CSR_MSTATUS, 32'h0000_1800);
        out_chk("rst2_epc", O_EPC, 32'h0);

        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
